// File: rtl/fpnew_slice_out_buffer.sv
// Elastic result buffer behind an FPnew format slice: a Depth-entry circular FIFO
// for result/status/extension bit/tag. Optional sticky status via FPNEW_OUTBUF_STICKY_EN.
module fpnew_slice_out_buffer #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 2,
  parameter type TagType = logic,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] result_i,
  input  logic [4:0]       status_i,
  input  logic             extension_bit_i,
  input  TagType           tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] result_o,
  output logic [4:0]       status_o,
  output logic             extension_bit_o,
  output TagType           tag_o,
  output logic [CntW-1:0]  usage_o,
  output logic             busy_o
`ifdef FPNEW_OUTBUF_STICKY_EN
  ,
  input  logic             sticky_clr_i,
  output logic [4:0]       sticky_status_o
`endif
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push, pop;

  logic [Width-1:0] result_mem [Depth];
  logic [4:0]       status_mem [Depth];
  logic             ext_mem    [Depth];
  TagType           tag_mem    [Depth];

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    return (ptr == LastPtr) ? '0 : ptr + PtrW'(1);
  endfunction

  // Ready depends only on the registered count, so out_ready_i never reaches in_ready_o.
  assign in_ready_o  = (count_q != FullCnt);
  assign out_valid_o = (count_q != '0);
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;
  assign usage_o     = count_q;
  assign busy_o      = out_valid_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is deliberately left unreset; only the pointers define what is live.
  always_ff @(posedge clk_i) begin
    if (rst_ni && !flush_i && push) begin
      result_mem[wr_ptr_q] <= result_i;
      status_mem[wr_ptr_q] <= status_i;
      ext_mem[wr_ptr_q]    <= extension_bit_i;
      tag_mem[wr_ptr_q]    <= tag_i;
    end
  end

  always_comb begin
    result_o        = '0;
    status_o        = '0;
    extension_bit_o = 1'b0;
    tag_o           = '0;
    if (out_valid_o) begin
      result_o        = result_mem[rd_ptr_q];
      status_o        = status_mem[rd_ptr_q];
      extension_bit_o = ext_mem[rd_ptr_q];
      tag_o           = tag_mem[rd_ptr_q];
    end
  end

`ifdef FPNEW_OUTBUF_STICKY_EN
  logic [4:0] sticky_q;

  // A pop discarded by flush does not contribute; flush itself leaves the flags alone.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sticky_q <= '0;
    end else if (sticky_clr_i) begin
      sticky_q <= '0;
    end else if (pop && !flush_i) begin
      sticky_q <= sticky_q | status_o;
    end
  end

  assign sticky_status_o = sticky_q;
`endif

endmodule

// File: tb/tb_fpnew_slice_out_buffer.sv
// Scoreboard bench for fpnew_slice_out_buffer: a Depth=2 and a Depth=3 instance,
// expected entries queued at issue time and checked by per-instance monitors.
module tb_fpnew_slice_out_buffer;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  status;
    logic        ext;
    logic        tag;
  } entry_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Depth=2 instance signals
  logic        flush2, in_valid2, in_ready2, out_valid2, out_ready2;
  logic [31:0] result2_i, result2_o;
  logic [4:0]  status2_i, status2_o;
  logic        ext2_i, ext2_o, tag2_i, tag2_o, busy2;
  logic [1:0]  usage2;

  // Depth=3 instance signals
  logic        flush3, in_valid3, in_ready3, out_valid3, out_ready3;
  logic [31:0] result3_i, result3_o;
  logic [4:0]  status3_i, status3_o;
  logic        ext3_i, ext3_o, tag3_i, tag3_o, busy3;
  logic [1:0]  usage3;

`ifdef FPNEW_OUTBUF_STICKY_EN
  logic        sticky_clr2;
  logic [4:0]  sticky2, sticky3;
`endif

  fpnew_slice_out_buffer #(.Width(32), .Depth(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush2),
    .in_valid_i(in_valid2), .in_ready_o(in_ready2),
    .result_i(result2_i), .status_i(status2_i), .extension_bit_i(ext2_i), .tag_i(tag2_i),
    .out_valid_o(out_valid2), .out_ready_i(out_ready2),
    .result_o(result2_o), .status_o(status2_o), .extension_bit_o(ext2_o), .tag_o(tag2_o),
    .usage_o(usage2), .busy_o(busy2)
`ifdef FPNEW_OUTBUF_STICKY_EN
    , .sticky_clr_i(sticky_clr2), .sticky_status_o(sticky2)
`endif
  );

  fpnew_slice_out_buffer #(.Width(32), .Depth(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush3),
    .in_valid_i(in_valid3), .in_ready_o(in_ready3),
    .result_i(result3_i), .status_i(status3_i), .extension_bit_i(ext3_i), .tag_i(tag3_i),
    .out_valid_o(out_valid3), .out_ready_i(out_ready3),
    .result_o(result3_o), .status_o(status3_o), .extension_bit_o(ext3_o), .tag_o(tag3_o),
    .usage_o(usage3), .busy_o(busy3)
`ifdef FPNEW_OUTBUF_STICKY_EN
    , .sticky_clr_i(1'b0), .sticky_status_o(sticky3)
`endif
  );

  entry_t q2[$];
  entry_t q3[$];
  int     cnt2 = 0;
  int     cnt3 = 0;
  int     pops3 = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: compare the head against the scoreboard whenever a handshake will occur.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && flush2 === 1'b0 && out_valid2 === 1'b1 && out_ready2 === 1'b1) begin
      if (q2.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL d2_unexpected_out: got result 0x%0h expected no entry", result2_o);
      end else begin
        entry_t e;
        e = q2.pop_front();
        checkOutput("d2_pop", 64'({result2_o, status2_o, ext2_o, tag2_o}), 64'(e));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && flush3 === 1'b0 && out_valid3 === 1'b1 && out_ready3 === 1'b1) begin
      if (q3.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL d3_unexpected_out: got result 0x%0h expected no entry", result3_o);
      end else begin
        entry_t e;
        e = q3.pop_front();
        pops3++;
        checkOutput("d3_pop", 64'({result3_o, status3_o, ext3_o, tag3_o}), 64'(e));
      end
    end
  end

  // Drives one cycle on the selected instance and updates the bench's occupancy model.
  task automatic applyStimulus(input int sel, input logic valid, input entry_t e,
                               input logic ready, input logic flush);
    logic accept, take;
    if (sel == 0) begin
      in_valid2 = valid; result2_i = e.result; status2_i = e.status;
      ext2_i = e.ext; tag2_i = e.tag; out_ready2 = ready; flush2 = flush;
      accept = valid && (cnt2 != 2);
      take   = ready && (cnt2 != 0);
    end else begin
      in_valid3 = valid; result3_i = e.result; status3_i = e.status;
      ext3_i = e.ext; tag3_i = e.tag; out_ready3 = ready; flush3 = flush;
      accept = valid && (cnt3 != 3);
      take   = ready && (cnt3 != 0);
    end
    @(posedge clk);
    #1;
    if (sel == 0) begin
      if (flush) begin
        cnt2 = 0;
        q2.delete();
      end else begin
        if (accept) q2.push_back(e);
        cnt2 = cnt2 + int'(accept) - int'(take);
      end
    end else begin
      if (flush) begin
        cnt3 = 0;
        q3.delete();
      end else begin
        if (accept) q3.push_back(e);
        cnt3 = cnt3 + int'(accept) - int'(take);
      end
    end
  endtask

  entry_t idle_e;
  entry_t ea, eb, ex, ec, ed, e1, e2, e3;

  initial begin
    idle_e = '0;
    ea = '{result: 32'h3F800000, status: 5'b00001, ext: 1'b1, tag: 1'b1};
    eb = '{result: 32'h40000000, status: 5'b10000, ext: 1'b0, tag: 1'b0};
    ex = '{result: 32'hDEADBEEF, status: 5'b01010, ext: 1'b1, tag: 1'b1};
    ec = '{result: 32'h40400000, status: 5'b00010, ext: 1'b1, tag: 1'b0};
    ed = '{result: 32'h40800000, status: 5'b01000, ext: 1'b0, tag: 1'b1};
    e1 = '{result: 32'h11111111, status: 5'b00011, ext: 1'b1, tag: 1'b1};
    e2 = '{result: 32'h22222222, status: 5'b00110, ext: 1'b0, tag: 1'b0};
    e3 = '{result: 32'h33333333, status: 5'b11000, ext: 1'b1, tag: 1'b1};

    rst_n = 1'b0;
    flush2 = 0; in_valid2 = 0; out_ready2 = 0; result2_i = 0; status2_i = 0; ext2_i = 0; tag2_i = 0;
    flush3 = 0; in_valid3 = 0; out_ready3 = 0; result3_i = 0; status3_i = 0; ext3_i = 0; tag3_i = 0;
`ifdef FPNEW_OUTBUF_STICKY_EN
    sticky_clr2 = 0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    checkOutput("reset_out_valid", 64'(out_valid2), 64'(0));
    checkOutput("reset_in_ready", 64'(in_ready2), 64'(1));
    checkOutput("reset_usage", 64'(usage2), 64'(0));
    checkOutput("reset_busy", 64'(busy2), 64'(0));
    checkOutput("reset_result", 64'(result2_o), 64'(0));
    checkOutput("reset_usage_d3", 64'(usage3), 64'(0));

    // Fill to capacity, then a third offer must be ignored.
    applyStimulus(0, 1, ea, 0, 0);
    applyStimulus(0, 1, eb, 0, 0);
    checkOutput("full_usage", 64'(usage2), 64'(2));
    checkOutput("full_in_ready", 64'(in_ready2), 64'(0));
    checkOutput("full_busy", 64'(busy2), 64'(1));
    applyStimulus(0, 1, ex, 0, 0);
    checkOutput("full_ignore_usage", 64'(usage2), 64'(2));
    checkOutput("full_head_held", 64'(result2_o), 64'(32'h3F800000));
    applyStimulus(0, 0, idle_e, 1, 0);
    checkOutput("drain1_usage", 64'(usage2), 64'(1));
    applyStimulus(0, 0, idle_e, 1, 0);
    checkOutput("drain2_usage", 64'(usage2), 64'(0));
    checkOutput("drain2_out_valid", 64'(out_valid2), 64'(0));

    // One-cycle latency, then simultaneous push and pop.
    applyStimulus(0, 1, ec, 0, 0);
    checkOutput("latency_out_valid", 64'(out_valid2), 64'(1));
    checkOutput("latency_result", 64'(result2_o), 64'(32'h40400000));
    applyStimulus(0, 1, ed, 1, 0);
    checkOutput("pushpop_usage", 64'(usage2), 64'(1));
    checkOutput("pushpop_head", 64'(result2_o), 64'(32'h40800000));
    applyStimulus(0, 0, idle_e, 1, 0);
    checkOutput("pushpop_drain_usage", 64'(usage2), 64'(0));

    // Flush a full buffer while offering another entry.
    applyStimulus(0, 1, e1, 0, 0);
    applyStimulus(0, 1, e2, 0, 0);
    applyStimulus(0, 1, e3, 1, 1);
    checkOutput("flush_usage", 64'(usage2), 64'(0));
    checkOutput("flush_out_valid", 64'(out_valid2), 64'(0));
    checkOutput("flush_in_ready", 64'(in_ready2), 64'(1));
    applyStimulus(0, 0, idle_e, 1, 0);
    applyStimulus(0, 0, idle_e, 1, 0);
    checkOutput("flush_stays_empty", 64'(usage2), 64'(0));

    // Depth=3: ten entries with random stalls on both sides.
    begin
      int sent = 0;
      int budget = 0;
      while (sent < 10 && budget < 200) begin
        entry_t e;
        logic v, r;
        e = '{result: 32'h1000_0000 + 32'(sent), status: 5'(sent), ext: sent[1], tag: sent[0]};
        v = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 2) != 0);
        if (v && cnt3 != 3) sent++;
        applyStimulus(1, v, e, r, 0);
        budget++;
      end
      for (int i = 0; i < 10 && cnt3 != 0; i++) applyStimulus(1, 0, idle_e, 1, 0);
      applyStimulus(1, 0, idle_e, 0, 0);
      checkOutput("d3_all_sent", 64'(sent), 64'(10));
      checkOutput("d3_all_popped", 64'(pops3), 64'(10));
      checkOutput("d3_final_usage", 64'(usage3), 64'(0));
    end

`ifdef FPNEW_OUTBUF_STICKY_EN
    sticky_clr2 = 1;
    applyStimulus(0, 0, idle_e, 0, 0);
    sticky_clr2 = 0;
    checkOutput("sticky_cleared", 64'(sticky2), 64'(0));
    applyStimulus(0, 1, '{result: 32'h1, status: 5'b00001, ext: 1'b0, tag: 1'b0}, 0, 0);
    applyStimulus(0, 1, '{result: 32'h2, status: 5'b10000, ext: 1'b0, tag: 1'b1}, 0, 0);
    applyStimulus(0, 0, idle_e, 1, 0);
    applyStimulus(0, 0, idle_e, 1, 0);
    checkOutput("sticky_or", 64'(sticky2), 64'(5'b10001));
    applyStimulus(0, 1, '{result: 32'h3, status: 5'b00100, ext: 1'b1, tag: 1'b0}, 0, 0);
    sticky_clr2 = 1;
    applyStimulus(0, 0, idle_e, 1, 0);
    sticky_clr2 = 0;
    checkOutput("sticky_clr_wins", 64'(sticky2), 64'(0));
`endif

    applyStimulus(0, 0, idle_e, 0, 0);
    checkOutput("q2_empty", 64'(q2.size()), 64'(0));
    checkOutput("q3_empty", 64'(q3.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
